uart_rx_frame_check: RTL and testbench

Parametrised UART receive frame checker, the successor to the single-purpose start-bit check. It consumes mid-bit samples from the RX sampler and validates the whole frame: start bit, configurable data width, optional even/odd parity, and 1 or 2 stop bits. It delivers the assembled data word with per-frame error pulses and keeps saturating error counters for status registers. It sits between the RX edge detector / oversampler and the RX FIFO.

---
 rtl/uart_rx_pkg.sv | 29 ++
 rtl/uart_sat_counter.sv | 34 +++
 rtl/uart_rx_frame_check.sv | 194 +++++++++++++++++++
 tb/tb_uart_rx_frame_check.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_rx_pkg.sv
// Shared types, parity-mode constants and parameter range checks for the
// UART receive frame checker.
package uart_rx_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } rx_state_t;

  localparam logic PAR_EVEN = 1'b0;
  localparam logic PAR_ODD  = 1'b1;

  function automatic bit data_width_ok(input int unsigned width);
    return (width >= 5) && (width <= 9);
  endfunction

  function automatic bit stop_bits_ok(input int unsigned bits);
    return (bits == 1) || (bits == 2);
  endfunction

  // ones_odd is the XOR of all data bits and the received parity bit.
  function automatic logic parity_error(input logic ones_odd, input logic mode);
    return (mode == PAR_EVEN) ? ones_odd : ~ones_odd;
  endfunction

endpackage

// File: rtl/uart_sat_counter.sv
// Saturating event counter; a synchronous clear wins over an increment.
module uart_sat_counter #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             clr,
  output logic [WIDTH-1:0] count
);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (inc && (count_q != '1)) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/uart_rx_frame_check.sv
// UART receive frame checker: validates start, data, optional parity and stop
// bits from mid-bit samples and reports per-frame errors plus running counts.
module uart_rx_frame_check
  import uart_rx_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned STOP_BITS  = 1,
  parameter int unsigned CNT_WIDTH  = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start_edge,
  input  logic                  bit_valid,
  input  logic                  sampled_bit,
  input  logic                  par_en,
  input  logic                  par_odd,
  input  logic                  clr_cnt,
  output logic                  busy,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  data_valid,
  output logic                  start_glitch,
  output logic                  parity_err,
  output logic                  stop_err,
  output logic [CNT_WIDTH-1:0]  glitch_cnt,
  output logic [CNT_WIDTH-1:0]  parity_cnt,
  output logic [CNT_WIDTH-1:0]  stop_cnt
);

  if (!data_width_ok(DATA_WIDTH)) begin : g_bad_data_width
    $error("uart_rx_frame_check: DATA_WIDTH must be in 5..9");
  end
  if (!stop_bits_ok(STOP_BITS)) begin : g_bad_stop_bits
    $error("uart_rx_frame_check: STOP_BITS must be 1 or 2");
  end

  localparam int unsigned IDX_W = $clog2(DATA_WIDTH);
  localparam logic [IDX_W-1:0] LAST_DATA = IDX_W'(DATA_WIDTH - 1);
  localparam logic [IDX_W-1:0] LAST_STOP = IDX_W'(STOP_BITS - 1);

  rx_state_t             state_q, state_d;
  logic [IDX_W-1:0]      bit_idx_q, bit_idx_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic                  par_en_q, par_en_d;
  logic                  par_odd_q, par_odd_d;
  logic                  par_flag_q, par_flag_d;
  logic                  stop_flag_q, stop_flag_d;
  logic                  busy_q, busy_d;
  logic [DATA_WIDTH-1:0] data_out_q, data_out_d;
  logic                  data_valid_q, data_valid_d;
  logic                  start_glitch_q, start_glitch_d;
  logic                  parity_err_q, parity_err_d;
  logic                  stop_err_q, stop_err_d;
  logic                  stop_now;

  // NOTE: every signal gets a default before the case so no path leaves one unassigned and infers a latch.
  always_comb begin
    state_d        = state_q;
    bit_idx_d      = bit_idx_q;
    shift_d        = shift_q;
    par_en_d       = par_en_q;
    par_odd_d      = par_odd_q;
    par_flag_d     = par_flag_q;
    stop_flag_d    = stop_flag_q;
    data_out_d     = data_out_q;
    data_valid_d   = 1'b0;
    start_glitch_d = 1'b0;
    parity_err_d   = 1'b0;
    stop_err_d     = 1'b0;
    stop_now       = stop_flag_q | ~sampled_bit;

    unique case (state_q)
      IDLE: begin
        if (start_edge) begin
          par_en_d  = par_en;
          par_odd_d = par_odd;
          state_d   = START;
        end
      end
      START: begin
        if (bit_valid) begin
          if (sampled_bit) begin
            start_glitch_d = 1'b1;
            state_d        = IDLE;
          end else begin
            bit_idx_d   = '0;
            par_flag_d  = 1'b0;
            stop_flag_d = 1'b0;
            state_d     = DATA;
          end
        end
      end
      DATA: begin
        if (bit_valid) begin
          shift_d = {sampled_bit, shift_q[DATA_WIDTH-1:1]};
          if (bit_idx_q == LAST_DATA) begin
            bit_idx_d = '0;
            state_d   = par_en_q ? PARITY : STOP;
          end else begin
            bit_idx_d = bit_idx_q + 1'b1;
          end
        end
      end
      PARITY: begin
        if (bit_valid) begin
          par_flag_d = parity_error(^shift_q ^ sampled_bit, par_odd_q);
          state_d    = STOP;
        end
      end
      STOP: begin
        if (bit_valid) begin
          stop_flag_d = stop_now;
          if (bit_idx_q == LAST_STOP) begin
            data_out_d   = shift_q;
            data_valid_d = 1'b1;
            parity_err_d = par_flag_q;
            stop_err_d   = stop_now;
            state_d      = IDLE;
          end else begin
            bit_idx_d = bit_idx_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= IDLE;
      bit_idx_q      <= '0;
      shift_q        <= '0;
      par_en_q       <= 1'b0;
      par_odd_q      <= 1'b0;
      par_flag_q     <= 1'b0;
      stop_flag_q    <= 1'b0;
      busy_q         <= 1'b0;
      data_out_q     <= '0;
      data_valid_q   <= 1'b0;
      start_glitch_q <= 1'b0;
      parity_err_q   <= 1'b0;
      stop_err_q     <= 1'b0;
    end else begin
      state_q        <= state_d;
      bit_idx_q      <= bit_idx_d;
      shift_q        <= shift_d;
      par_en_q       <= par_en_d;
      par_odd_q      <= par_odd_d;
      par_flag_q     <= par_flag_d;
      stop_flag_q    <= stop_flag_d;
      busy_q         <= busy_d;
      data_out_q     <= data_out_d;
      data_valid_q   <= data_valid_d;
      start_glitch_q <= start_glitch_d;
      parity_err_q   <= parity_err_d;
      stop_err_q     <= stop_err_d;
    end
  end

  assign busy         = busy_q;
  assign data_out     = data_out_q;
  assign data_valid   = data_valid_q;
  assign start_glitch = start_glitch_q;
  assign parity_err   = parity_err_q;
  assign stop_err     = stop_err_q;

  // Counters step on the same edge that registers the matching pulse.
  uart_sat_counter #(.WIDTH(CNT_WIDTH)) u_glitch_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (start_glitch_d),
    .clr   (clr_cnt),
    .count (glitch_cnt)
  );

  uart_sat_counter #(.WIDTH(CNT_WIDTH)) u_parity_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (parity_err_d),
    .clr   (clr_cnt),
    .count (parity_cnt)
  );

  uart_sat_counter #(.WIDTH(CNT_WIDTH)) u_stop_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (stop_err_d),
    .clr   (clr_cnt),
    .count (stop_cnt)
  );

endmodule

// File: tb/tb_uart_rx_frame_check.sv
// Scoreboard bench: two checkers (8-bit/1 stop/8-bit counters and
// 8-bit/2 stop/2-bit counters) receive identical sample streams.
module tb_uart_rx_frame_check;
  import uart_rx_pkg::*;

  logic clk, rst, start_edge, bit_valid, sampled_bit, par_en, par_odd, clr_cnt;

  logic       a_busy, a_data_valid, a_start_glitch, a_parity_err, a_stop_err;
  logic [7:0] a_data_out, a_glitch_cnt, a_parity_cnt, a_stop_cnt;
  logic       b_busy, b_data_valid, b_start_glitch, b_parity_err, b_stop_err;
  logic [7:0] b_data_out;
  logic [1:0] b_glitch_cnt, b_parity_cnt, b_stop_cnt;

  uart_rx_frame_check #(.DATA_WIDTH(8), .STOP_BITS(1), .CNT_WIDTH(8)) dut_a (
    .clk(clk), .rst(rst), .start_edge(start_edge), .bit_valid(bit_valid),
    .sampled_bit(sampled_bit), .par_en(par_en), .par_odd(par_odd), .clr_cnt(clr_cnt),
    .busy(a_busy), .data_out(a_data_out), .data_valid(a_data_valid),
    .start_glitch(a_start_glitch), .parity_err(a_parity_err), .stop_err(a_stop_err),
    .glitch_cnt(a_glitch_cnt), .parity_cnt(a_parity_cnt), .stop_cnt(a_stop_cnt)
  );

  uart_rx_frame_check #(.DATA_WIDTH(8), .STOP_BITS(2), .CNT_WIDTH(2)) dut_b (
    .clk(clk), .rst(rst), .start_edge(start_edge), .bit_valid(bit_valid),
    .sampled_bit(sampled_bit), .par_en(par_en), .par_odd(par_odd), .clr_cnt(clr_cnt),
    .busy(b_busy), .data_out(b_data_out), .data_valid(b_data_valid),
    .start_glitch(b_start_glitch), .parity_err(b_parity_err), .stop_err(b_stop_err),
    .glitch_cnt(b_glitch_cnt), .parity_cnt(b_parity_cnt), .stop_cnt(b_stop_cnt)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       glitch;
    logic [7:0] data;
    logic       perr;
    logic       serr;
  } exp_t;

  exp_t q_a[$];
  exp_t q_b[$];
  int n_vec = 0;
  int n_err = 0;
  int ga, pa, sa, gb, pb, sb;
  logic [7:0] last_a, last_b;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int sat_inc(input int v, input int maxv);
    return (v < maxv) ? v + 1 : v;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic b, input logic edge_too);
    bit_valid   = 1'b1;
    sampled_bit = b;
    start_edge  = edge_too;
    tick();
    bit_valid  = 1'b0;
    start_edge = 1'b0;
    tick();
  endtask

  task automatic open_frame(input logic pe, input logic po);
    start_edge = 1'b1;
    par_en     = pe;
    par_odd    = po;
    tick();
    start_edge = 1'b0;
    par_en     = 1'b0;
    par_odd    = 1'b0;
    check("a_busy_rise", 32'(a_busy), 32'd1);
    check("b_busy_rise", 32'(b_busy), 32'd1);
    tick();
  endtask

  task automatic drain_and_check();
    int k = 0;
    while ((q_a.size() != 0 || q_b.size() != 0) && k < 20) begin
      tick();
      k++;
    end
    check("drain_pending", 32'(q_a.size() + q_b.size()), 32'd0);
    check("a_busy_idle", 32'(a_busy), 32'd0);
    check("b_busy_idle", 32'(b_busy), 32'd0);
    check("a_data_hold", 32'(a_data_out), 32'(last_a));
    check("b_data_hold", 32'(b_data_out), 32'(last_b));
    check("a_glitch_cnt", 32'(a_glitch_cnt), 32'(ga));
    check("a_parity_cnt", 32'(a_parity_cnt), 32'(pa));
    check("a_stop_cnt", 32'(a_stop_cnt), 32'(sa));
    check("b_glitch_cnt", 32'(b_glitch_cnt), 32'(gb));
    check("b_parity_cnt", 32'(b_parity_cnt), 32'(pb));
    check("b_stop_cnt", 32'(b_stop_cnt), 32'(sb));
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_a_busy"}, 32'(a_busy), 32'd0);
    check({tag, "_a_data"}, 32'(a_data_out), 32'd0);
    check({tag, "_a_pulses"}, 32'({a_data_valid, a_start_glitch, a_parity_err, a_stop_err}), 32'd0);
    check({tag, "_a_cnts"}, 32'({a_glitch_cnt, a_parity_cnt, a_stop_cnt}), 32'd0);
    check({tag, "_b_busy"}, 32'(b_busy), 32'd0);
    check({tag, "_b_data"}, 32'(b_data_out), 32'd0);
    check({tag, "_b_pulses"}, 32'({b_data_valid, b_start_glitch, b_parity_err, b_stop_err}), 32'd0);
    check({tag, "_b_cnts"}, 32'({b_glitch_cnt, b_parity_cnt, b_stop_cnt}), 32'd0);
  endtask

  task automatic send_glitch(input logic with_clr);
    exp_t e;
    open_frame(1'b0, PAR_EVEN);
    e = '{glitch: 1'b1, data: 8'h00, perr: 1'b0, serr: 1'b0};
    q_a.push_back(e);
    q_b.push_back(e);
    ga = sat_inc(ga, 255);
    gb = sat_inc(gb, 3);
    if (with_clr) begin
      ga = 0; pa = 0; sa = 0;
      gb = 0; pb = 0; sb = 0;
    end
    clr_cnt     = with_clr;
    bit_valid   = 1'b1;
    sampled_bit = 1'b1;
    tick();
    bit_valid = 1'b0;
    clr_cnt   = 1'b0;
    check("a_busy_after_glitch", 32'(a_busy), 32'd0);
    check("b_busy_after_glitch", 32'(b_busy), 32'd0);
    tick();
    drain_and_check();
  endtask

  task automatic send_frame(input logic [7:0] data, input logic pe, input logic po,
                            input logic pbit, input logic s1, input logic s2);
    exp_t ea, eb;
    logic ones;
    ones = ^data ^ pbit;
    ea.glitch = 1'b0;
    ea.data   = data;
    ea.perr   = pe && (po ? !ones : ones);
    ea.serr   = !s1;
    eb        = ea;
    eb.serr   = !s1 || !s2;
    q_a.push_back(ea);
    q_b.push_back(eb);
    if (ea.perr) begin
      pa = sat_inc(pa, 255);
      pb = sat_inc(pb, 3);
    end
    if (ea.serr) sa = sat_inc(sa, 255);
    if (eb.serr) sb = sat_inc(sb, 3);
    last_a = data;
    last_b = data;
    open_frame(pe, po);
    send_bit(1'b0, 1'b0);
    for (int i = 0; i < 8; i++) send_bit(data[i], !data[i]);
    if (pe) send_bit(pbit, 1'b0);
    send_bit(s1, 1'b0);
    send_bit(s2, 1'b0);
    drain_and_check();
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (!rst && (a_data_valid || a_start_glitch || a_parity_err || a_stop_err)) begin
      if (q_a.size() == 0) begin
        check("a_spurious_pulse", 32'(q_a.size()), 32'd1);
      end else begin
        e = q_a.pop_front();
        check("a_start_glitch", 32'(a_start_glitch), 32'(e.glitch));
        check("a_data_valid", 32'(a_data_valid), 32'(!e.glitch));
        check("a_parity_err", 32'(a_parity_err), 32'(e.perr));
        check("a_stop_err", 32'(a_stop_err), 32'(e.serr));
        if (!e.glitch) check("a_data_out", 32'(a_data_out), 32'(e.data));
      end
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (!rst && (b_data_valid || b_start_glitch || b_parity_err || b_stop_err)) begin
      if (q_b.size() == 0) begin
        check("b_spurious_pulse", 32'(q_b.size()), 32'd1);
      end else begin
        e = q_b.pop_front();
        check("b_start_glitch", 32'(b_start_glitch), 32'(e.glitch));
        check("b_data_valid", 32'(b_data_valid), 32'(!e.glitch));
        check("b_parity_err", 32'(b_parity_err), 32'(e.perr));
        check("b_stop_err", 32'(b_stop_err), 32'(e.serr));
        if (!e.glitch) check("b_data_out", 32'(b_data_out), 32'(e.data));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected bench completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    clk = 1'b0; rst = 1'b1;
    start_edge = 1'b0; bit_valid = 1'b0; sampled_bit = 1'b1;
    par_en = 1'b0; par_odd = 1'b0; clr_cnt = 1'b0;
    ga = 0; pa = 0; sa = 0; gb = 0; pb = 0; sb = 0;
    last_a = 8'h00; last_b = 8'h00;
    #12;
    check_all_zero("reset");
    tick();
    rst = 1'b0;
    tick();

    send_frame(8'hA5, 1'b0, PAR_EVEN, 1'b0, 1'b1, 1'b1);  // 8N1 clean
    send_glitch(1'b0);
    send_frame(8'h3C, 1'b0, PAR_EVEN, 1'b0, 1'b1, 1'b1);
    send_frame(8'h07, 1'b1, PAR_EVEN, 1'b0, 1'b1, 1'b1);  // even parity error
    send_frame(8'h07, 1'b1, PAR_ODD,  1'b0, 1'b1, 1'b1);  // odd parity ok
    send_frame(8'h07, 1'b1, PAR_EVEN, 1'b0, 1'b1, 1'b0);  // parity + 2nd stop error
    send_frame(8'h81, 1'b0, PAR_EVEN, 1'b0, 1'b0, 1'b1);  // 1st stop error

    for (int i = 0; i < 5; i++) send_glitch(1'b0);       // 2-bit counter saturates
    send_glitch(1'b1);                                   // clear beats increment
    send_frame(8'hC3, 1'b1, PAR_ODD, 1'b1, 1'b0, 1'b1);

    // Abort a frame after four data bits.
    open_frame(1'b0, PAR_EVEN);
    send_bit(1'b0, 1'b0);
    for (int i = 0; i < 4; i++) send_bit(1'b1, 1'b0);
    rst = 1'b1;
    #1;
    check_all_zero("midframe_rst");
    ga = 0; pa = 0; sa = 0; gb = 0; pb = 0; sb = 0;
    last_a = 8'h00; last_b = 8'h00;
    tick();
    tick();
    rst = 1'b0;
    tick();
    send_frame(8'h5A, 1'b0, PAR_EVEN, 1'b0, 1'b1, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
